// File: rtl/podule_pkg.sv
// Shared types and default tables for the podule address decoder.
// Tables are packed with region 0 in the least significant slot.
package podule_pkg;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam int unsigned REG_ROM    = 0;
    localparam int unsigned REG_ECONET = 1;
    localparam int unsigned REG_IDE    = 2;
    localparam int unsigned REG_IDE_HI = 3;
    localparam int unsigned REG_PAGE   = 4;
    localparam int unsigned REG_UART   = 5;
    localparam int unsigned REG_ETH    = 6;
    localparam int unsigned REG_INT    = 7;

    localparam logic [95:0] DEFAULT_MASK = {12'hF00, 12'hF00, 12'hF00, 12'hF00,
                                            12'hF00, 12'hD00, 12'hF00, 12'h800};
    localparam logic [95:0] DEFAULT_MATCH = {12'hF00, 12'hE00, 12'hD00, 12'hC00,
                                             12'hA00, 12'h900, 12'h800, 12'h000};
    localparam logic [31:0] DEFAULT_WAIT = {4'd0, 4'd3, 4'd2, 4'd0, 4'd1, 4'd4, 4'd3, 4'd2};

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/podule_region_match.sv
// Combinational mask/match table compare with lowest-index-wins priority.
module podule_region_match #(
    parameter int unsigned NUM_REGIONS = 8,
    parameter int unsigned AW = 12,
    parameter int unsigned IW = 3,
    parameter logic [NUM_REGIONS*AW-1:0] REGION_MASK = '0,
    parameter logic [NUM_REGIONS*AW-1:0] REGION_MATCH = '0
) (
    input  logic [AW-1:0]          a,
    output logic                   hit_valid,
    output logic [IW-1:0]          hit_idx,
    output logic [NUM_REGIONS-1:0] hit_onehot
);

    always_comb begin
        hit_valid  = 1'b0;
        hit_idx    = '0;
        hit_onehot = '0;
        // Walk downwards so the lowest matching index is the last one written.
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((a & REGION_MASK[i*AW +: AW]) == REGION_MATCH[i*AW +: AW]) begin
                hit_valid = 1'b1;
                hit_idx   = IW'(i);
            end
        end
        if (hit_valid) begin
            hit_onehot[hit_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/podule_decode_ws.sv
// Clocked podule address decoder: registered one-hot chip selects, per-region
// wait states, ready handshake and the ROM page latch.
module podule_decode_ws
    import podule_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = 8,
    parameter int unsigned AW = 12,
    parameter logic [NUM_REGIONS*AW-1:0] REGION_MASK = DEFAULT_MASK,
    parameter logic [NUM_REGIONS*AW-1:0] REGION_MATCH = DEFAULT_MATCH,
    parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = DEFAULT_WAIT,
    parameter int unsigned PAGE_REGION = REG_PAGE,
    parameter int unsigned PAGE_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AW-1:0]          a,
    input  logic                   strobe,
    input  logic                   wr,
    input  logic [7:0]             wdata,
    output logic [NUM_REGIONS-1:0] cs,
    output logic                   ready,
    output logic                   miss,
    output logic [PAGE_W-1:0]      rom_page
);

    localparam int unsigned IW = idx_width(NUM_REGIONS);
    localparam logic [IW-1:0] PAGE_IDX = IW'(PAGE_REGION);

    if (NUM_REGIONS < 1 || NUM_REGIONS > 16) begin : g_bad_num_regions
        $error("NUM_REGIONS must be in 1..16");
    end
    if (PAGE_REGION >= NUM_REGIONS) begin : g_bad_page_region
        $error("PAGE_REGION must be below NUM_REGIONS");
    end
    if (PAGE_W > 8 || PAGE_W < 1) begin : g_bad_page_w
        $error("PAGE_W must be in 1..8");
    end

    logic                   hit_valid;
    logic [IW-1:0]          hit_idx;
    logic [NUM_REGIONS-1:0] hit_onehot;
    logic [3:0]             hit_wait;

    state_e                 state_q, state_d;
    logic [NUM_REGIONS-1:0] cs_q, cs_d;
    logic                   ready_q, ready_d;
    logic                   miss_q, miss_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   wr_q, wr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic [PAGE_W-1:0]      page_q, page_d;
    logic                   unused_wdata;

    podule_region_match #(
        .NUM_REGIONS  (NUM_REGIONS),
        .AW           (AW),
        .IW           (IW),
        .REGION_MASK  (REGION_MASK),
        .REGION_MATCH (REGION_MATCH)
    ) u_match (
        .a          (a),
        .hit_valid  (hit_valid),
        .hit_idx    (hit_idx),
        .hit_onehot (hit_onehot)
    );

    assign hit_wait     = REGION_WAIT[hit_idx*4 +: 4];
    assign unused_wdata = ^wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (strobe) state_d = hit_valid ? StAccess : StDone;
            StAccess: begin
                if (!strobe) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end
            end
            StDone:   if (!strobe) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cs_d    = cs_q;
        ready_d = ready_q;
        miss_d  = miss_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        page_d  = page_q;
        unique case (state_q)
            StIdle: begin
                if (strobe) begin
                    idx_d   = hit_idx;
                    wr_d    = wr;
                    wdata_d = wdata;
                    cs_d    = hit_onehot;
                    miss_d  = ~hit_valid;
                    cnt_d   = hit_valid ? hit_wait : 4'd0;
                    ready_d = 1'b0;
                end
            end
            StAccess: begin
                if (!strobe) begin
                    // Aborted cycle: drop selects, never raise ready, no page write.
                    cs_d  = '0;
                    cnt_d = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    if (wr_q && idx_q == PAGE_IDX) begin
                        page_d = wdata_q[PAGE_W-1:0];
                    end
                end
            end
            StDone: begin
                if (!strobe) begin
                    cs_d    = '0;
                    ready_d = 1'b0;
                    miss_d  = 1'b0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: begin
                cs_d    = '0;
                ready_d = 1'b0;
                miss_d  = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q    <= '0;
            ready_q <= 1'b0;
            miss_q  <= 1'b0;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= 8'h00;
            page_q  <= '0;
        end else begin
            cs_q    <= cs_d;
            ready_q <= ready_d;
            miss_q  <= miss_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            page_q  <= page_d;
        end
    end

    assign cs       = cs_q;
    assign ready    = ready_q;
    assign miss     = miss_q;
    assign rom_page = page_q;

endmodule

// File: tb/tb_podule_decode_ws.sv
// Directed bench: default table plus two re-parameterised decoders sharing the bus.
module tb_podule_decode_ws;

    localparam logic [95:0] MASK_ALL = {12'h000, 12'hF00, 12'hF00, 12'hF00,
                                        12'hF00, 12'hD00, 12'hF00, 12'h000};
    localparam logic [95:0] MATCH_ALL = {12'h000, 12'hE00, 12'hD00, 12'hC00,
                                         12'hA00, 12'h900, 12'h800, 12'h001};
    localparam logic [83:0] MASK_7 = {12'hF00, 12'hF00, 12'hF00, 12'hF00,
                                      12'hD00, 12'hF00, 12'h000};
    localparam logic [83:0] MATCH_7 = {12'hE00, 12'hD00, 12'hC00, 12'hA00,
                                       12'h900, 12'h800, 12'h001};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] a = 12'h000;
    logic        strobe = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  wdata = 8'h00;

    logic [7:0] cs0, cs1;
    logic [6:0] cs2;
    logic       ready0, ready1, ready2;
    logic       miss0, miss1, miss2;
    logic [5:0] page0, page1, page2;

    int errors = 0;
    int checks = 0;

    // Results captured by run_cycle
    int         lat0, lat1, lat2;
    logic [7:0] cs_k0, cs_k1, cs_k2;
    logic       miss_k0, miss_k2;
    logic [5:0] page_k, page_r;

    always #5 clk = ~clk;

    podule_decode_ws dut (
        .clk(clk), .rst(rst), .a(a), .strobe(strobe), .wr(wr), .wdata(wdata),
        .cs(cs0), .ready(ready0), .miss(miss0), .rom_page(page0)
    );

    podule_decode_ws #(
        .NUM_REGIONS(8), .AW(12), .REGION_MASK(MASK_ALL), .REGION_MATCH(MATCH_ALL),
        .REGION_WAIT(32'h0320_1432), .PAGE_REGION(4), .PAGE_W(6)
    ) dut_all (
        .clk(clk), .rst(rst), .a(a), .strobe(strobe), .wr(wr), .wdata(wdata),
        .cs(cs1), .ready(ready1), .miss(miss1), .rom_page(page1)
    );

    podule_decode_ws #(
        .NUM_REGIONS(7), .AW(12), .REGION_MASK(MASK_7), .REGION_MATCH(MATCH_7),
        .REGION_WAIT(28'h320_1432), .PAGE_REGION(4), .PAGE_W(6)
    ) dut_miss (
        .clk(clk), .rst(rst), .a(a), .strobe(strobe), .wr(wr), .wdata(wdata),
        .cs(cs2), .ready(ready2), .miss(miss2), .rom_page(page2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a cycle; edge k is the first edge that sees strobe high. Latencies are
    // edges after k at which ready was first seen, -1 if never within the budget.
    task automatic run_cycle(input logic [11:0] addr, input logic w, input logic [7:0] d);
        a = addr; wr = w; wdata = d; strobe = 1'b1;
        tick();
        cs_k0 = cs0; cs_k1 = cs1; cs_k2 = {1'b0, cs2};
        miss_k0 = miss0; miss_k2 = miss2; page_k = page0; page_r = page0;
        lat0 = -1; lat1 = -1; lat2 = -1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (ready0 && lat0 < 0) begin lat0 = e; page_r = page0; end
            if (ready1 && lat1 < 0) lat1 = e;
            if (ready2 && lat2 < 0) lat2 = e;
            if (lat0 >= 0 && lat1 >= 0 && lat2 >= 0) break;
        end
    endtask

    task automatic end_cycle();
        strobe = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (cs0 !== 8'h00) begin errors++; $display("FAIL reset_cs got %h want 00", cs0); end
        checks++; if (ready0 !== 1'b0 || miss0 !== 1'b0) begin
            errors++; $display("FAIL reset_ready_miss got %b%b want 00", ready0, miss0);
        end
        checks++; if (page0 !== 6'h00) begin errors++; $display("FAIL reset_page got %h want 00", page0); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rom_read();
        run_cycle(12'h000, 1'b0, 8'h00);
        checks++; if (cs_k0 !== 8'h01) begin errors++; $display("FAIL rom_cs got %h want 01", cs_k0); end
        checks++; if (lat0 != 3) begin errors++; $display("FAIL rom_latency got %0d want 3", lat0); end
        checks++; if (miss_k0 !== 1'b0) begin errors++; $display("FAIL rom_miss got %b want 0", miss_k0); end
        // Strobe held high: selects and ready stay, no second cycle starts.
        tick(); tick(); tick();
        checks++; if (ready0 !== 1'b1 || cs0 !== 8'h01) begin
            errors++; $display("FAIL rom_hold got ready=%b cs=%h want 1/01", ready0, cs0);
        end
        end_cycle();
        checks++; if (cs0 !== 8'h00 || ready0 !== 1'b0) begin
            errors++; $display("FAIL rom_clear got cs=%h ready=%b want 00/0", cs0, ready0);
        end
    endtask

    task automatic test_ide_alias();
        run_cycle(12'hB04, 1'b0, 8'h00);
        checks++; if (cs_k0 !== 8'h04) begin errors++; $display("FAIL ide_b04_cs got %h want 04", cs_k0); end
        checks++; if (lat0 != 5) begin errors++; $display("FAIL ide_b04_latency got %0d want 5", lat0); end
        end_cycle();
        run_cycle(12'h904, 1'b0, 8'h00);
        checks++; if (cs_k0 !== 8'h04) begin errors++; $display("FAIL ide_904_cs got %h want 04", cs_k0); end
        checks++; if (lat0 != 5) begin errors++; $display("FAIL ide_904_latency got %0d want 5", lat0); end
        end_cycle();
    endtask

    task automatic test_page_latch();
        run_cycle(12'hC00, 1'b1, 8'hA5);
        checks++; if (cs_k0 !== 8'h10) begin errors++; $display("FAIL page_cs got %h want 10", cs_k0); end
        checks++; if (lat0 != 1) begin errors++; $display("FAIL page_latency got %0d want 1", lat0); end
        checks++; if (page_k !== 6'h00) begin errors++; $display("FAIL page_early got %h want 00", page_k); end
        checks++; if (page_r !== 6'h25) begin errors++; $display("FAIL page_write got %h want 25", page_r); end
        end_cycle();
        run_cycle(12'hC00, 1'b0, 8'h3C);
        checks++; if (page0 !== 6'h25) begin errors++; $display("FAIL page_read_keep got %h want 25", page0); end
        end_cycle();
    endtask

    task automatic test_match_all_and_miss();
        run_cycle(12'h400, 1'b0, 8'h00);
        checks++; if (cs_k1 !== 8'h80) begin errors++; $display("FAIL matchall_cs got %h want 80", cs_k1); end
        checks++; if (lat1 != 1) begin errors++; $display("FAIL matchall_latency got %0d want 1", lat1); end
        checks++; if (cs_k2 !== 8'h00) begin errors++; $display("FAIL miss_cs got %h want 00", cs_k2); end
        checks++; if (miss_k2 !== 1'b1) begin errors++; $display("FAIL miss_flag got %b want 1", miss_k2); end
        checks++; if (lat2 != 1) begin errors++; $display("FAIL miss_latency got %0d want 1", lat2); end
        end_cycle();
        checks++; if (miss2 !== 1'b0 || ready2 !== 1'b0) begin
            errors++; $display("FAIL miss_clear got miss=%b ready=%b want 0/0", miss2, ready2);
        end
    endtask

    task automatic test_abort();
        logic seen_ready;
        seen_ready = 1'b0;
        a = 12'hE00; wr = 1'b0; strobe = 1'b1;
        tick();
        checks++; if (cs0 !== 8'h40) begin errors++; $display("FAIL abort_cs_k got %h want 40", cs0); end
        tick(); seen_ready |= ready0;
        tick(); seen_ready |= ready0;
        strobe = 1'b0;
        tick(); seen_ready |= ready0;
        checks++; if (cs0 !== 8'h00) begin errors++; $display("FAIL abort_cs got %h want 00", cs0); end
        checks++; if (dut.state_q !== podule_pkg::StIdle) begin
            errors++; $display("FAIL abort_state got %0d want idle", dut.state_q);
        end
        tick(); seen_ready |= ready0;
        tick(); seen_ready |= ready0;
        checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got 1 want 0"); end
        run_cycle(12'h000, 1'b0, 8'h00);
        checks++; if (cs_k0 !== 8'h01 || lat0 != 3) begin
            errors++; $display("FAIL abort_next got cs=%h lat=%0d want 01/3", cs_k0, lat0);
        end
        end_cycle();
    endtask

    task automatic test_back_to_back();
        run_cycle(12'hD00, 1'b0, 8'h00);
        end_cycle();
        run_cycle(12'h800, 1'b0, 8'h00);
        checks++; if (cs_k0 !== 8'h02 || lat0 != 4) begin
            errors++; $display("FAIL b2b_econet got cs=%h lat=%0d want 02/4", cs_k0, lat0);
        end
        end_cycle();
    endtask

    task automatic test_reset_mid_cycle();
        checks++; if (page0 !== 6'h25) begin errors++; $display("FAIL pre_rst_page got %h want 25", page0); end
        a = 12'hD00; wr = 1'b0; strobe = 1'b1;
        tick();
        checks++; if (cs0 !== 8'h20) begin errors++; $display("FAIL uart_cs got %h want 20", cs0); end
        #2 rst = 1'b1;
        #1;
        checks++; if (cs0 !== 8'h00 || ready0 !== 1'b0 || miss0 !== 1'b0) begin
            errors++; $display("FAIL async_rst got cs=%h ready=%b miss=%b want 00/0/0", cs0, ready0, miss0);
        end
        checks++; if (page0 !== 6'h00) begin errors++; $display("FAIL async_rst_page got %h want 00", page0); end
        strobe = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rom_read();
        test_ide_alias();
        test_page_latch();
        test_match_all_and_miss();
        test_abort();
        test_back_to_back();
        test_reset_mid_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
